// File: rtl/shr_pkg.sv
// Shared definitions for the sequential right shifter: FSM state encoding and
// the operation-mode encoding passed from the accept stage into the step datapath.
// Latency: n/a (types and constants only). Backpressure: n/a.
package shr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shr_state_t;

    // Operation modes: what fills the vacated MSBs.
    localparam logic [1:0] SHR_LOGIC = 2'd0;  // zero fill
    localparam logic [1:0] SHR_ARITH = 2'd1;  // sign fill
    localparam logic [1:0] SHR_ROT   = 2'd2;  // bits shifted out of the LSBs

    // Rotate wins over arithmetic when both are requested.
    function automatic logic [1:0] shr_mode(input logic arith, input logic rot);
        if (rot)
            return SHR_ROT;
        else if (arith)
            return SHR_ARITH;
        else
            return SHR_LOGIC;
    endfunction

endpackage

// File: rtl/shr_step.sv
// One step of the right shifter: shifts data_i right by k_i (0..STEP) bits and
// fills the vacated MSBs with zeros, the sign, or the rotated-out LSBs.
// Latency: combinational. Backpressure: none (pure function of its inputs).
// Ports: data_i operand, k_i step amount, mode_i fill select, sign_i latched
//        sign bit, data_o shifted result.
module shr_step
    import shr_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 2,
    localparam int K_W  = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [K_W-1:0]   k_i,
    input  logic [1:0]       mode_i,
    input  logic             sign_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] fill;

    always_comb begin
        fill = '0;
        if (mode_i == SHR_ROT)
            fill = data_i;
        else if (mode_i == SHR_ARITH)
            fill = {WIDTH{sign_i}};

        // The low k bits of 'fill' land in the top k positions; for rotate these
        // are exactly the bits dropped off the bottom. k=0 is excluded so the
        // fill shift never reaches WIDTH.
        data_o = data_i >> k_i;
        if (k_i != '0)
            data_o = data_o | (fill << (WIDTH - int'(k_i)));
    end

endmodule

// File: rtl/seq_right_shifter.sv
// Multi-cycle logical/arithmetic right shifter, up to STEP bits per clock.
// Latency: result valid ceil(shamt/STEP)+1 cycles after the accept cycle.
// Backpressure: result held in DONE until out_ready; no new request taken until then.
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_data/in_shamt/in_arith
//        request side; out_valid/out_ready/out_data result side; busy = SHIFT or DONE.
// Optional: define SHR_ROTATE_EN to add the in_rot port (rotate right, beats in_arith).
module seq_right_shifter
    import shr_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int STEP     = 2,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef SHR_ROTATE_EN
    input  logic               in_rot,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_arith,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy
);

    localparam int               K_W      = $clog2(STEP + 1);
    localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

    shr_state_t         state_q;
    logic [WIDTH-1:0]   data_q;
    logic [SHAMT_W-1:0] rem_q;
    logic [1:0]         mode_q;
    logic               sign_q;
    logic [WIDTH-1:0]   out_data_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [1:0]         mode_d;
    logic [SHAMT_W-1:0] k_amt_d;
    logic [K_W-1:0]     k_d;
    logic [WIDTH-1:0]   step_d;

    always_comb begin
`ifdef SHR_ROTATE_EN
        mode_d = shr_mode(in_arith, in_rot);
`else
        mode_d = shr_mode(in_arith, 1'b0);
`endif
    end

    // This cycle's step: min(STEP, remaining).
    assign k_amt_d = (rem_q > STEP_AMT) ? STEP_AMT : rem_q;
    assign k_d     = K_W'(k_amt_d);

    shr_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .data_i (data_q),
        .k_i    (k_d),
        .mode_i (mode_q),
        .sign_i (sign_q),
        .data_o (step_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            rem_q       <= '0;
            mode_q      <= SHR_LOGIC;
            sign_q      <= 1'b0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        data_q     <= in_data;
                        rem_q      <= in_shamt;
                        mode_q     <= mode_d;
                        sign_q     <= in_data[WIDTH-1];
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (in_shamt == '0) begin
                            // Nothing to shift: the operand is the result.
                            state_q     <= DONE;
                            out_data_q  <= in_data;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    data_q <= step_d;
                    rem_q  <= rem_q - k_amt_d;
                    if (rem_q == k_amt_d) begin
                        state_q     <= DONE;
                        out_data_q  <= step_d;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // Return to IDLE only; a waiting request is taken next cycle.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seq_right_shifter.sv
// Bench for seq_right_shifter (WIDTH=32, STEP=2): vector table driven through a
// scoreboard (data + latency), plus hand sequences for zero shift, backpressure
// and reset during a shift.
module tb_seq_right_shifter;

    localparam int WIDTH   = 32;
    localparam int STEP    = 2;
    localparam int SHAMT_W = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_rot = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data = '0;
    logic [SHAMT_W-1:0] in_shamt = '0;
    logic               in_arith = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [WIDTH-1:0]   out_data;
    logic               busy;

    seq_right_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef SHR_ROTATE_EN
        .in_rot    (in_rot),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_arith  (in_arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int errs    = 0;

    typedef struct {
        logic [31:0] dat;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [31:0] data;
        logic [4:0]  shamt;
        logic        arith;
        logic        rot;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: bit i of the result comes from bit i+sh of the operand, or the fill.
    function automatic logic [31:0] model(input logic [31:0] d, input int sh,
                                          input logic ar, input logic rt);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            if (i + sh < 32)
                r[i] = d[i + sh];
            else if (rt)
                r[i] = d[i + sh - 32];
            else
                r[i] = ar & d[31];
        end
        return r;
    endfunction

    // Monitor: checks latency when out_valid rises and data at each handshake.
    logic prev_ov = 1'b0;
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sbq.size() == 0) begin
                    vectors++;
                    errs++;
                    $display("FAIL unexpected_out: got %h, expected no result", out_data);
                end else begin
                    check("latency", 32'(cyc - sbq[0].acc), 32'(sbq[0].lat));
                end
            end
            if (out_valid && out_ready && sbq.size() > 0) begin
                check("out_data", out_data, sbq[0].dat);
                void'(sbq.pop_front());
            end
            prev_ov = out_valid;
        end
    end

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic send(input logic [31:0] d, input logic [4:0] sh, input logic ar,
                        input logic rt, input logic [31:0] exp);
        exp_t e;
        int   n;
        in_data  = d;
        in_shamt = sh;
        in_arith = ar;
        in_rot   = rt;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            vectors++;
            errs++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1 within 100 cycles");
        end
        e.dat = exp;
        e.lat = (int'(sh) + STEP - 1) / STEP + 1;
        e.acc = cyc;
        sbq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        in_shamt = 5'($urandom_range(0, 31));
        in_arith = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            vectors++;
            errs++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [4:0]  s;
        logic        a;
        logic        r;
        int          bc;
        int          n;

        vecs.push_back('{32'hF000_0000, 5'd4,  1'b0, 1'b0, 32'h0F00_0000});
        vecs.push_back('{32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'hFFFF_FFFF});
        vecs.push_back('{32'h8000_0000, 5'd31, 1'b0, 1'b0, 32'h0000_0001});
        vecs.push_back('{32'h1234_5678, 5'd0,  1'b0, 1'b0, 32'h1234_5678});
        vecs.push_back('{32'h7FFF_FFFF, 5'd1,  1'b1, 1'b0, 32'h3FFF_FFFF});
        vecs.push_back('{32'h8000_000F, 5'd3,  1'b1, 1'b0, 32'hF000_0001});
        vecs.push_back('{32'hA5A5_A5A5, 5'd16, 1'b0, 1'b0, 32'h0000_A5A5});
        vecs.push_back('{32'hA5A5_A5A5, 5'd16, 1'b1, 1'b0, 32'hFFFF_A5A5});
`ifdef SHR_ROTATE_EN
        vecs.push_back('{32'h0000_0001, 5'd1,  1'b0, 1'b1, 32'h8000_0000});
        vecs.push_back('{32'h0000_000F, 5'd3,  1'b0, 1'b1, 32'hE000_0001});
        vecs.push_back('{32'h0000_000F, 5'd3,  1'b1, 1'b1, 32'hE000_0001});
`endif
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            s = 5'($urandom_range(0, 31));
            a = 1'($urandom_range(0, 1));
`ifdef SHR_ROTATE_EN
            r = 1'($urandom_range(0, 1));
`else
            r = 1'b0;
`endif
            vecs.push_back('{d, s, a, r, model(d, int'(s), a, r)});
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  out_data,       32'h0);
        check("rst_busy",      32'(busy),      32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table, back to back
        foreach (vecs[i])
            send(vecs[i].data, vecs[i].shamt, vecs[i].arith, vecs[i].rot, vecs[i].exp);
        drain();

        // Zero shift: busy for exactly one cycle
        @(negedge clk);
        send(32'h1234_5678, 5'd0, 1'b0, 1'b0, 32'h1234_5678);
        bc = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy) bc++;
            @(negedge clk);
        end
        check("zero_busy_cycles", 32'(bc), 32'd1);
        drain();

        // Backpressure in DONE with a request waiting upstream
        out_ready = 1'b0;
        send(32'hF000_0000, 5'd4, 1'b0, 1'b0, 32'h0F00_0000);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        in_data  = 32'h0000_00F0;
        in_shamt = 5'd4;
        in_arith = 1'b0;
        in_rot   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_data",  out_data,       32'h0F00_0000);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        check("bp_release_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("bp_idle_in_ready", 32'(in_ready), 32'd1);
        send(32'h0000_00F0, 5'd4, 1'b0, 1'b0, 32'h0000_000F);
        drain();

        // Reset in the 3rd SHIFT cycle of a 20-bit shift
        send(32'hDEAD_BEEF, 5'd20, 1'b1, 1'b0, 32'hFFFF_FDEA);
        @(negedge clk);
        @(negedge clk);
        check("mid_busy",      32'(busy),      32'd1);
        check("mid_out_valid", 32'(out_valid), 32'd0);
        sbq.delete();
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_out_data",  out_data,       32'h0);
        check("mrst_in_ready",  32'(in_ready),  32'd1);
        check("mrst_busy",      32'(busy),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(32'h0000_00F0, 5'd4, 1'b0, 1'b0, 32'h0000_000F);
        drain();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
